// File: rtl/tms_sdm_decim.sv
// Counting decimator: sums OUT1+OUT2 ones per channel over 2^N sample strobes, then
// streams the frozen per-channel sums as a channel-tagged valid/ready frame.
module tms_sdm_decim #(
    parameter int unsigned NCH  = 19,
    parameter int unsigned ACCW = 17
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic [NCH*2-1:0]  SDM_DIN,
    input  logic              SAMPLE_EN,
    input  logic [3:0]        WINDOW_LOG2,
    input  logic              OVF_CLEAR,
    output logic [ACCW-1:0]   DOUT_DATA,
    output logic [7:0]        DOUT_CH,
    output logic              DOUT_LAST,
    output logic              DOUT_VALID,
    input  logic              DOUT_READY,
    output logic [15:0]       FRAME_CNT,
    output logic              OVERFLOW
);

    typedef enum logic {StIdle, StSend} state_e;

    state_e          state_q, state_d;
    logic [7:0]      ch_q, ch_d;
    logic [3:0]      neff_q, neff_clamp;
    logic [15:0]     cnt_q, win_last;
    logic [15:0]     frame_q;
    logic            ovf_q;
    logic            boundary, hs, last_beat;
    logic [1:0]      contrib [NCH];
    logic [ACCW-1:0] sum     [NCH];
    logic [ACCW-1:0] acc_q   [NCH];
    logic [ACCW-1:0] shadow_q[NCH];

    assign neff_clamp = (WINDOW_LOG2 < 4'd4) ? 4'd4 : WINDOW_LOG2;
    assign win_last   = (16'd1 << neff_q) - 16'd1;
    assign boundary   = SAMPLE_EN && (cnt_q == win_last);
    assign hs         = DOUT_VALID && DOUT_READY;
    assign last_beat  = (ch_q == 8'(NCH - 1));

    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            contrib[i] = {1'b0, SDM_DIN[2*i]} + {1'b0, SDM_DIN[2*i+1]};
            sum[i]     = acc_q[i] + ACCW'(contrib[i]);
        end
    end

    always_comb begin
        state_d = state_q;
        ch_d    = ch_q;
        unique case (state_q)
            StIdle: begin
                if (boundary) begin
                    state_d = StSend;
                    ch_d    = 8'd0;
                end
            end
            StSend: begin
                if (hs) begin
                    if (last_beat) begin
                        state_d = StIdle;
                        ch_d    = 8'd0;
                    end else begin
                        ch_d = ch_q + 8'd1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        DOUT_DATA = '0;
        for (int i = 0; i < NCH; i++) begin
            if (ch_q == 8'(i)) DOUT_DATA = shadow_q[i];
        end
    end

    assign DOUT_VALID = (state_q == StSend);
    assign DOUT_CH    = ch_q;
    assign DOUT_LAST  = DOUT_VALID && last_beat;
    assign FRAME_CNT  = frame_q;
    assign OVERFLOW   = ovf_q;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= StIdle;
            ch_q    <= 8'd0;
            cnt_q   <= 16'd0;
            neff_q  <= neff_clamp;
            frame_q <= 16'd0;
            ovf_q   <= 1'b0;
            for (int i = 0; i < NCH; i++) begin
                acc_q[i]    <= '0;
                shadow_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            ch_q    <= ch_d;
            if (SAMPLE_EN) begin
                if (boundary) begin
                    cnt_q  <= 16'd0;
                    neff_q <= neff_clamp;
                end else begin
                    cnt_q <= cnt_q + 16'd1;
                end
                for (int i = 0; i < NCH; i++) acc_q[i] <= boundary ? '0 : sum[i];
            end
            // A window closing while a frame is still in flight is dropped whole.
            if (boundary && (state_q == StIdle)) begin
                for (int i = 0; i < NCH; i++) shadow_q[i] <= sum[i];
            end
            if (hs && last_beat) frame_q <= frame_q + 16'd1;
            if (boundary && (state_q == StSend)) ovf_q <= 1'b1;
            else if (OVF_CLEAR)                  ovf_q <= 1'b0;
        end
    end

endmodule

// File: tb/tb_tms_sdm_decim.sv
// Scoreboard bench for tms_sdm_decim: stimulus pushes hand-computed beats, a negedge
// monitor pops and compares on every handshake.
module tb_tms_sdm_decim;

    localparam int NCH = 19;
    localparam int W   = NCH * 2;

    typedef struct {
        logic [7:0]  ch;
        logic [16:0] data;
        logic        last;
    } beat_t;

    logic          clk = 1'b0;
    logic          rst;
    logic [W-1:0]  din;
    logic          sample_en;
    logic [3:0]    wlog2;
    logic          ovf_clear;
    logic [16:0]   dout_data;
    logic [7:0]    dout_ch;
    logic          dout_last;
    logic          dout_valid;
    logic          dout_ready;
    logic [15:0]   frame_cnt;
    logic          overflow;

    int            n_vec = 0;
    int            n_bad = 0;
    beat_t         exp_q[$];
    logic          toggle_ready = 1'b0;
    logic [W-1:0]  ones;

    always #5 clk = ~clk;

    tms_sdm_decim #(.NCH(NCH), .ACCW(17)) dut (
        .CLK        (clk),
        .RESET      (rst),
        .SDM_DIN    (din),
        .SAMPLE_EN  (sample_en),
        .WINDOW_LOG2(wlog2),
        .OVF_CLEAR  (ovf_clear),
        .DOUT_DATA  (dout_data),
        .DOUT_CH    (dout_ch),
        .DOUT_LAST  (dout_last),
        .DOUT_VALID (dout_valid),
        .DOUT_READY (dout_ready),
        .FRAME_CNT  (frame_cnt),
        .OVERFLOW   (overflow)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    task automatic do_reset(input logic [3:0] wl);
        rst       = 1'b1;
        sample_en = 1'b0;
        ovf_clear = 1'b0;
        din       = '0;
        wlog2     = wl;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic push_frame(input logic [16:0] d0, input logic [16:0] dn, input int upto);
        beat_t b;
        for (int i = 0; i <= upto; i++) begin
            b.ch   = 8'(i);
            b.data = (i == 0) ? d0 : dn;
            b.last = (i == NCH - 1);
            exp_q.push_back(b);
        end
    endtask

    task automatic strobes(input int n, input int gap, input logic [W-1:0] d);
        for (int i = 0; i < n; i++) begin
            din       = d;
            sample_en = 1'b1;
            tick();
            sample_en = 1'b0;
            repeat (gap - 1) tick();
        end
    endtask

    task automatic drain(input int budget);
        int k;
        for (k = 0; k < budget; k++) begin
            if (exp_q.size() == 0 && !dout_valid) break;
            tick();
        end
        n_vec++;
        if (k == budget) begin
            n_bad++;
            $display("FAIL drain: %0d beats outstanding, valid %0d, required 0 and 0",
                     exp_q.size(), dout_valid);
        end
    endtask

    // Monitor: hold-stability during stalls and scoreboard pop on each handshake.
    initial begin
        logic        prev_stall;
        logic [16:0] prev_data;
        logic [7:0]  prev_ch;
        beat_t       e;
        prev_stall = 1'b0;
        prev_data  = '0;
        prev_ch    = '0;
        forever begin
            @(negedge clk);
            if (prev_stall && dout_valid) begin
                n_vec++;
                if (dout_data !== prev_data || dout_ch !== prev_ch) begin
                    n_bad++;
                    $display("FAIL hold: ch %0d data %0d, required ch %0d data %0d",
                             dout_ch, dout_data, prev_ch, prev_data);
                end
            end
            prev_stall = dout_valid && !dout_ready;
            prev_data  = dout_data;
            prev_ch    = dout_ch;
            if (dout_valid && dout_ready) begin
                n_vec++;
                if (exp_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL beat: unexpected ch %0d data %0d, required no beat",
                             dout_ch, dout_data);
                end else begin
                    e = exp_q.pop_front();
                    if (dout_ch !== e.ch || dout_data !== e.data || dout_last !== e.last) begin
                        n_bad++;
                        $display("FAIL beat: ch %0d data %0d last %0d, required %0d %0d %0d",
                                 dout_ch, dout_data, dout_last, e.ch, e.data, e.last);
                    end
                end
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (toggle_ready) dout_ready = ~dout_ready;
        end
    end

    initial begin
        ones       = '1;
        dout_ready = 1'b1;

        // Reset state
        do_reset(4'd4);
        chk("rst_valid", 32'(dout_valid), 0);
        chk("rst_data", 32'(dout_data), 0);
        chk("rst_ch", 32'(dout_ch), 0);
        chk("rst_last", 32'(dout_last), 0);
        chk("rst_frame", 32'(frame_cnt), 0);
        chk("rst_ovf", 32'(overflow), 0);

        // All ones, strobe every 4th cycle: 16 samples * 2 = 32, valid 1 clk after 16th edge
        push_frame(17'd32, 17'd32, NCH - 1);
        for (int i = 0; i < 16; i++) begin
            din       = ones;
            sample_en = 1'b1;
            if (i == 15) chk("pre_valid", 32'(dout_valid), 0);
            tick();
            sample_en = 1'b0;
            if (i == 15) begin
                chk("lat_valid", 32'(dout_valid), 1);
                chk("lat_ch", 32'(dout_ch), 0);
            end
            repeat (3) tick();
        end
        drain(100);
        chk("ones_frame", 32'(frame_cnt), 1);

        // Channel 0 OUT1 alternating over a 32-sample window, two windows, no carry-over
        do_reset(4'd5);
        push_frame(17'd16, 17'd0, NCH - 1);
        push_frame(17'd16, 17'd0, NCH - 1);
        for (int i = 0; i < 64; i++) strobes(1, 2, (i % 2 == 0) ? W'(1) : W'(0));
        drain(100);
        chk("alt_frame", 32'(frame_cnt), 2);

        // Backpressure: ready toggles, strobe every 8 cycles
        do_reset(4'd4);
        toggle_ready = 1'b1;
        push_frame(17'd32, 17'd32, NCH - 1);
        push_frame(17'd32, 17'd32, NCH - 1);
        strobes(32, 8, ones);
        drain(200);
        toggle_ready = 1'b0;
        tick();
        dout_ready = 1'b1;
        chk("bp_ovf", 32'(overflow), 0);
        chk("bp_frame", 32'(frame_cnt), 2);

        // Overflow: ready stuck low, second window dropped
        do_reset(4'd4);
        dout_ready = 1'b0;
        strobes(32, 1, ones);
        chk("ovf_set", 32'(overflow), 1);
        chk("ovf_frame0", 32'(frame_cnt), 0);
        push_frame(17'd32, 17'd32, NCH - 1);
        dout_ready = 1'b1;
        drain(100);
        chk("ovf_frame1", 32'(frame_cnt), 1);
        chk("ovf_sticky", 32'(overflow), 1);
        ovf_clear = 1'b1;
        tick();
        ovf_clear = 1'b0;
        chk("ovf_clear", 32'(overflow), 0);

        // Low clamp: WINDOW_LOG2=2 behaves as a 16-sample window
        do_reset(4'd2);
        push_frame(17'd32, 17'd32, NCH - 1);
        strobes(16, 1, ones);
        drain(100);

        // Window change mid-window: current window stays 16, next is 64
        do_reset(4'd4);
        push_frame(17'd32, 17'd32, NCH - 1);
        push_frame(17'd128, 17'd128, NCH - 1);
        strobes(8, 1, ones);
        wlog2 = 4'd6;
        strobes(8, 1, ones);
        strobes(64, 1, ones);
        drain(100);
        chk("chg_frame", 32'(frame_cnt), 2);

        // Maximum window: 2^15 samples of all ones
        do_reset(4'd15);
        push_frame(17'd65536, 17'd65536, NCH - 1);
        strobes(32768, 1, ones);
        drain(100);

        // Reset mid-frame after channel 7 is accepted
        do_reset(4'd4);
        push_frame(17'd32, 17'd32, 7);
        strobes(16, 1, ones);
        begin
            int k;
            for (k = 0; k < 100; k++) begin
                @(negedge clk);
                if (dout_valid && dout_ready && dout_ch == 8'd7) break;
            end
            if (k == 100) chk("wait_ch7", 0, 1);
        end
        @(posedge clk);
        #1;
        rst        = 1'b1;
        dout_ready = 1'b0;
        tick();
        chk("mid_valid", 32'(dout_valid), 0);
        chk("mid_frame", 32'(frame_cnt), 0);
        chk("mid_q", 32'(exp_q.size()), 0);
        rst        = 1'b0;
        dout_ready = 1'b1;
        // Only OUT2 of each channel set: 16 per channel
        push_frame(17'd16, 17'd16, NCH - 1);
        strobes(16, 1, {NCH{2'b10}});
        drain(100);
        chk("mid_frame1", 32'(frame_cnt), 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/tms_sdm_decim.md
Name: tms_sdm_decim

Overview:
- Per-channel counting decimator for the TMS SDM bitstreams.
- Sits directly downstream of the SDM receiver and consumes its registered NCH*2-bit sample word.
- Counts the ones in SDM_OUT1 + SDM_OUT2 over a programmable window of 2^N sample strobes.
- At each window boundary, freezes all channel sums into a shadow bank and serialises them as a channel-tagged valid/ready stream toward the readout FIFO.

Parameters:
- NCH, 19, number of SDM channels; input word is NCH*2 bits.
- ACCW, 17, accumulator/output width; holds the max sum 2*2^15 = 65536.

Ports:
- CLK  input  1  system clock; all logic synchronous to it.
- RESET  input  1  synchronous, active-high reset.
- SDM_DIN  input  NCH*2  sample word; bit 2i = OUT1 of channel i, bit 2i+1 = OUT2 of channel i.
- SAMPLE_EN  input  1  one-cycle strobe, high when SDM_DIN holds a new SDM sample (at the CLKFF rate).
- WINDOW_LOG2  input  4  window length exponent N; effective N clamped to 4..15.
- OVF_CLEAR  input  1  pulse; clears OVERFLOW.
- DOUT_DATA  output  ACCW  channel sum.
- DOUT_CH  output  8  channel index of DOUT_DATA.
- DOUT_LAST  output  1  high with channel NCH-1.
- DOUT_VALID  output  1  stream valid.
- DOUT_READY  input  1  stream ready from consumer.
- FRAME_CNT  output  16  count of windows emitted; wraps at 65535 -> 0.
- OVERFLOW  output  1  sticky; a completed window was dropped.

Behaviour:
- Reset: all accumulators, the shadow bank and the sample counter go to 0. Outputs on reset: DOUT_VALID=0, DOUT_DATA=0, DOUT_CH=0, DOUT_LAST=0, FRAME_CNT=0, OVERFLOW=0. The serialiser goes to IDLE. Reset mid-stream aborts the frame with no partial-frame completion.
- Sample contribution per channel: c_i = SDM_DIN[2i] + SDM_DIN[2i+1], range 0..2. Cycles with SAMPLE_EN=0 are ignored.
- Window length:
  - Neff = clamp(WINDOW_LOG2, 4, 15).
  - Neff is latched at reset release and at each window boundary; changes mid-window apply only to the next window.
  - The sample counter counts accepted samples 0..2^Neff-1.
- Boundary edge: the edge accepting the sample with counter = 2^Neff-1.
  - shadow_i <= acc_i + c_i; acc_i <= 0; counter <= 0.
  - The next window starts with the next strobe. No sample is lost or double-counted.
- Non-boundary accepted sample: acc_i <= acc_i + c_i.
- Serialiser FSM:
  - IDLE -> SEND at the boundary edge if IDLE. DOUT_VALID rises the cycle after that edge (latency 1 clock), with DOUT_CH=0 and DOUT_DATA=shadow_0.
  - SEND: on a handshake (VALID & READY), if DOUT_CH=NCH-1 -> IDLE, DOUT_VALID=0, FRAME_CNT+1. Otherwise DOUT_CH+1 with the matching shadow value.
  - While VALID=1 and READY=0, DATA/CH/LAST are held stable.
  - A full frame takes NCH handshakes; throughput is one channel per cycle with READY held high.
- Boundary while in SEND:
  - The shadow bank is not overwritten and the new window's sums are discarded.
  - OVERFLOW <= 1; FRAME_CNT is not incremented for the dropped window.
  - Accumulation of the following window proceeds normally.
- Boundary on the same edge as the final handshake (CH=NCH-1): counts as SEND, so the window is dropped and OVERFLOW is set.
- OVF_CLEAR coincident with a new overflow event: set wins.
- Arithmetic: unsigned. ACCW is sized so no accumulator overflow is possible at Neff=15.
- NCH > 256 is unsupported (DOUT_CH width).

Test Plan:
- All ones: RESET then WINDOW_LOG2=4, SDM_DIN all ones, SAMPLE_EN every 4th cycle, READY=1 -> 19 beats, each DATA=32, CH 0..18, LAST only on CH 18, FRAME_CNT=1, first VALID exactly 1 cycle after the 16th strobe edge.
- Per-channel bits: channel 0 OUT1 alternating 1/0, OUT2=0, other channels 0, WINDOW_LOG2=5 -> ch0 DATA=16, all others 0; the next window also gives ch0=16 (no carry-over).
- Backpressure: READY toggled 1/0 each cycle with SAMPLE_EN every 8 cycles at N=4 -> no overflow, DATA/CH stable across every READY=0 cycle, all frames complete.
- Overflow: READY=0 permanently, SAMPLE_EN every cycle, N=4 -> second boundary sets OVERFLOW=1 and FRAME_CNT stays 0. Then READY=1 -> first frame emitted intact. OVF_CLEAR -> OVERFLOW=0.
- Clamping and window change: WINDOW_LOG2=2 -> window is 16 samples; WINDOW_LOG2=15 with all ones -> DATA=65536 per channel; changing 4->6 mid-window -> current window stays 16, the next is 64.
- Reset mid-frame: assert RESET after CH=7 is accepted -> next cycle VALID=0 and FRAME_CNT=0; after release, a fresh 16-sample window yields correct sums with no stale data.
